// File: rtl/riscv_pkg.sv
// Shared RV32I-subset definitions: opcodes, ALU operation encoding, operand-select codes
// and the control bundle handed from decode to the ID/EX register.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9
    } alu_ops_t;

    localparam logic [1:0] SRC_RS1_RS2 = 2'b00;
    localparam logic [1:0] SRC_RS1_IMM = 2'b01;
    localparam logic [1:0] SRC_PC_IMM  = 2'b10;
    localparam logic [1:0] SRC_ZERO_IMM = 2'b11;

    typedef struct packed {
        logic     mem_to_reg;
        logic     reg_write;
        logic     mem_write;
        logic     mem_read;
        logic     branch;
        logic     mem_size;
        alu_ops_t alu_op;
        logic [1:0] alu_src;
        logic     imm_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        mem_write:  1'b0,
        mem_read:   1'b0,
        branch:     1'b0,
        mem_size:   1'b1,
        alu_op:     ALU_NOP,
        alu_src:    SRC_RS1_RS2,
        imm_type:   1'b0
    };

endpackage

// File: rtl/reg_file_32x32.sv
// 32-entry architectural register file: x0 hard-wired to zero, one write port,
// two combinational read ports with write-through bypass from the same-cycle write.
module reg_file_32x32 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [4:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [4:0]    raddr1,
    input  logic [4:0]    raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs [32];

    assign regs[0] = '0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
        logic [DW-1:0] reg_q;
        logic [DW-1:0] reg_d;

        always_comb begin
            reg_d = reg_q;
            if (we && (waddr == 5'(gi))) begin
                reg_d = wdata;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs[gi] = reg_q;
    end

    // Bypass lets an instruction in ID see the value WB is retiring this very cycle.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && (waddr == raddr1) && (raddr1 != 5'd0)) begin
            rdata1 = wdata;
        end
        if (we && (waddr == raddr2) && (raddr2 != 5'd0)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// RV32I-subset decode stage: combinational decode, register-file read and
// load-use hazard detection between IF/ID and ID/EX.
module id_decode_stage
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [31:0]           instr_in,
    input  logic                  wb_we,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  ex_MemRead,
    input  logic [4:0]            ex_rd_addr,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  Branch,
    output logic                  MemSize,
    output logic [3:0]            ALUOp,
    output logic [1:0]            ALUSrc,
    output logic [ADDR_WIDTH-1:0] PC_out,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    output logic [4:0]            rd_addr,
    output logic                  imm_type,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  load_use_hazard,
    output logic                  illegal_instr
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ctrl_t       ctrl;
    alu_ops_t    alu_sel;
    logic        legal;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic [31:0] imm32;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    always_comb begin
        ctrl          = CTRL_NOP;
        alu_sel       = ALU_NOP;
        legal         = 1'b0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        use_rd        = 1'b0;
        imm32         = '0;
        illegal_instr = 1'b0;

        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        alu_sel = (funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
                        legal   = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                    end
                    3'b111: begin alu_sel = ALU_AND; legal = (funct7 == FUNCT7_BASE); end
                    3'b110: begin alu_sel = ALU_OR;  legal = (funct7 == FUNCT7_BASE); end
                    3'b100: begin alu_sel = ALU_XOR; legal = (funct7 == FUNCT7_BASE); end
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_sel;
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                    use_rd         = 1'b1;
                end
            end
            OP_I: begin
                imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
                case (funct3)
                    3'b000: begin alu_sel = ALU_ADD; legal = 1'b1; end
                    3'b111: begin alu_sel = ALU_AND; legal = 1'b1; end
                    3'b110: begin alu_sel = ALU_OR;  legal = 1'b1; end
                    3'b100: begin alu_sel = ALU_XOR; legal = 1'b1; end
                    3'b001: begin
                        alu_sel = ALU_SLL;
                        legal   = (funct7 == FUNCT7_BASE);
                        imm32   = {27'd0, instr_in[24:20]};
                    end
                    3'b101: begin
                        alu_sel = instr_in[30] ? ALU_SRA : ALU_SRL;
                        legal   = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                        imm32   = {27'd0, instr_in[24:20]};
                    end
                    default: legal = 1'b0;
                endcase
                if (legal) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = alu_sel;
                    ctrl.alu_src   = SRC_RS1_IMM;
                    ctrl.imm_type  = 1'b1;
                    use_rs1        = 1'b1;
                    use_rd         = 1'b1;
                end
            end
            OP_LOAD: begin
                legal = (funct3 == 3'b000) || (funct3 == 3'b010);
                if (legal) begin
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_size   = funct3[1];
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.alu_src    = SRC_RS1_IMM;
                    ctrl.imm_type   = 1'b1;
                    imm32           = {{20{instr_in[31]}}, instr_in[31:20]};
                    use_rs1         = 1'b1;
                    use_rd          = 1'b1;
                end
            end
            OP_STORE: begin
                legal = (funct3 == 3'b000) || (funct3 == 3'b010);
                if (legal) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.mem_size  = funct3[1];
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.alu_src   = SRC_RS1_IMM;
                    ctrl.imm_type  = 1'b1;
                    imm32          = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
                    use_rs1        = 1'b1;
                    use_rs2        = 1'b1;
                end
            end
            OP_BRANCH: begin
                legal = (funct3 == 3'b000);
                if (legal) begin
                    ctrl.branch   = 1'b1;
                    ctrl.alu_op   = ALU_SUB;
                    ctrl.imm_type = 1'b1;
                    imm32         = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                                     instr_in[30:25], instr_in[11:8], 1'b0};
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
            end
            OP_LUI, OP_AUIPC: begin
                legal          = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = (opcode == OP_LUI) ? SRC_ZERO_IMM : SRC_PC_IMM;
                ctrl.imm_type  = 1'b1;
                imm32          = {instr_in[31:12], 12'd0};
                use_rd         = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // A flushed IF/ID slot carries all zeros and must pass as a silent bubble.
        if (!legal) begin
            ctrl          = CTRL_NOP;
            imm32         = '0;
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
            use_rd        = 1'b0;
            illegal_instr = (instr_in != 32'd0);
        end
    end

    assign rs1_addr = use_rs1 ? instr_in[19:15] : 5'd0;
    assign rs2_addr = use_rs2 ? instr_in[24:20] : 5'd0;
    assign rd_addr  = use_rd  ? instr_in[11:7]  : 5'd0;

    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign MemWrite = ctrl.mem_write;
    assign MemRead  = ctrl.mem_read;
    assign Branch   = ctrl.branch;
    assign MemSize  = ctrl.mem_size;
    assign ALUOp    = ctrl.alu_op;
    assign ALUSrc   = ctrl.alu_src;
    assign imm_type = ctrl.imm_type;
    assign imm      = DATA_WIDTH'($signed(imm32));
    assign PC_out   = pc_in;

    assign load_use_hazard = ex_MemRead && (ex_rd_addr != 5'd0) &&
                             ((ex_rd_addr == rs1_addr) || (ex_rd_addr == rs2_addr));

    reg_file_32x32 #(
        .DW(DATA_WIDTH)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: register-file bypass/reset, hazard detection
// and decode of representative instructions against hand-computed values.
module tb_id_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_MemRead;
    logic [4:0]  ex_rd_addr;
    logic        MemtoReg, RegWrite, MemWrite, MemRead, Branch, MemSize;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrc;
    logic [31:0] PC_out;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        imm_type;
    logic [31:0] imm;
    logic        load_use_hazard;
    logic        illegal_instr;

    int n_checks = 0;
    int n_fail   = 0;

    id_decode_stage #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .instr_in        (instr_in),
        .wb_we           (wb_we),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .ex_MemRead      (ex_MemRead),
        .ex_rd_addr      (ex_rd_addr),
        .MemtoReg        (MemtoReg),
        .RegWrite        (RegWrite),
        .MemWrite        (MemWrite),
        .MemRead         (MemRead),
        .Branch          (Branch),
        .MemSize         (MemSize),
        .ALUOp           (ALUOp),
        .ALUSrc          (ALUSrc),
        .PC_out          (PC_out),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rd_addr         (rd_addr),
        .imm_type        (imm_type),
        .imm             (imm),
        .load_use_hazard (load_use_hazard),
        .illegal_instr   (illegal_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        pc_in      = 32'h0000_0100;
        instr_in   = 32'h0052_8333;   // ADD x6,x5,x5
        wb_we      = 1'b0;
        wb_addr    = 5'd0;
        wb_data    = 32'd0;
        ex_MemRead = 1'b0;
        ex_rd_addr = 5'd0;
        #2;
        check_val("reset_rs1_data", rs1_data, 32'h0);
        check_val("reset_illegal", 32'(illegal_instr), 32'h0);
        check_val("reset_regwrite_comb", 32'(RegWrite), 32'h1);
        next_cycle();
        reset = 1'b0;

        // Write-through bypass, then the array value on the following cycle.
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        #1;
        check_val("bypass_rs1", rs1_data, 32'h0000_1234);
        check_val("bypass_rs2", rs2_data, 32'h0000_1234);
        check_val("add_rd_addr", 32'(rd_addr), 32'd6);
        next_cycle();
        wb_we = 1'b0;
        #1;
        check_val("array_rs1", rs1_data, 32'h0000_1234);

        // Writes to x0 are dropped, with no bypass either.
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        instr_in = 32'h0000_0333;     // ADD x6,x0,x0
        #1;
        check_val("x0_bypass", rs1_data, 32'h0);
        next_cycle();
        wb_we = 1'b0;
        #1;
        check_val("x0_array", rs2_data, 32'h0);

        // Load-use hazard.
        ex_MemRead = 1'b1; ex_rd_addr = 5'd5;
        instr_in = 32'h0012_8333;     // ADD x6,x5,x1
        #1;
        check_val("hazard_rs1", 32'(load_use_hazard), 32'h1);
        ex_rd_addr = 5'd1;
        #1;
        check_val("hazard_rs2", 32'(load_use_hazard), 32'h1);
        ex_rd_addr = 5'd0;
        #1;
        check_val("hazard_x0", 32'(load_use_hazard), 32'h0);
        ex_rd_addr = 5'd5;
        instr_in = 32'h1234_52B7;     // LUI x5,0x12345
        #1;
        check_val("hazard_lui", 32'(load_use_hazard), 32'h0);
        check_val("lui_rs1_addr", 32'(rs1_addr), 32'h0);
        check_val("lui_imm", imm, 32'h1234_5000);
        check_val("lui_alusrc", 32'(ALUSrc), 32'h3);
        ex_MemRead = 1'b0;

        instr_in = 32'hFE21_AE23;     // SW x2,-4(x3)
        #1;
        check_val("sw_memwrite", 32'(MemWrite), 32'h1);
        check_val("sw_memsize", 32'(MemSize), 32'h1);
        check_val("sw_alusrc", 32'(ALUSrc), 32'h1);
        check_val("sw_imm", imm, 32'hFFFF_FFFC);
        check_val("sw_rd_addr", 32'(rd_addr), 32'h0);
        check_val("sw_regwrite", 32'(RegWrite), 32'h0);

        instr_in = 32'h0030_8383;     // LB x7,3(x1)
        #1;
        check_val("lb_memread", 32'(MemRead), 32'h1);
        check_val("lb_memtoreg", 32'(MemtoReg), 32'h1);
        check_val("lb_memsize", 32'(MemSize), 32'h0);
        check_val("lb_imm", imm, 32'h3);
        check_val("lb_aluop", 32'(ALUOp), 32'h1);
        check_val("lb_rd_addr", 32'(rd_addr), 32'd7);

        instr_in = 32'h4052_5193;     // SRAI x3,x4,5
        #1;
        check_val("srai_aluop", 32'(ALUOp), 32'h9);
        check_val("srai_imm", imm, 32'h5);
        check_val("srai_rs2_addr", 32'(rs2_addr), 32'h0);

        pc_in = 32'h0000_0200;
        instr_in = 32'h0000_1097;     // AUIPC x1,1
        #1;
        check_val("auipc_alusrc", 32'(ALUSrc), 32'h2);
        check_val("auipc_imm", imm, 32'h0000_1000);
        check_val("auipc_pc_out", PC_out, 32'h0000_0200);

        instr_in = 32'hFFFF_FFFF;
        #1;
        check_val("ill_flag", 32'(illegal_instr), 32'h1);
        check_val("ill_regwrite", 32'(RegWrite), 32'h0);
        check_val("ill_memsize", 32'(MemSize), 32'h1);
        check_val("ill_aluop", 32'(ALUOp), 32'h0);
        check_val("ill_rd_addr", 32'(rd_addr), 32'h0);

        instr_in = 32'h0000_0000;
        #1;
        check_val("zero_illegal", 32'(illegal_instr), 32'h0);
        check_val("zero_regwrite", 32'(RegWrite), 32'h0);

        // Async reset clears a committed register immediately.
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5_A5A5;
        next_cycle();
        wb_we = 1'b0;
        instr_in = 32'hFE04_8CE3;     // BEQ x9,x0,-8
        #1;
        check_val("x9_written", rs1_data, 32'hA5A5_A5A5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("x9_async_reset", rs1_data, 32'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_val("beq_branch", 32'(Branch), 32'h1);
        check_val("beq_aluop", 32'(ALUOp), 32'h2);
        check_val("beq_rs1_data", rs1_data, 32'h0);
        check_val("beq_imm", imm, 32'hFFFF_FFF8);
        check_val("beq_rd_addr", 32'(rd_addr), 32'h0);

        // A write presented while reset is held is lost.
        reset = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0055;
        next_cycle();
        reset = 1'b0;
        wb_we = 1'b0;
        #1;
        check_val("write_during_reset", rs1_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
